// File: rtl/inst_fetch_if.sv
// Handshake bundle for inst_fetch: CPU-side request/result signals and W_* bus read port.
// The fetch unit takes the master view; the CPU/bus environment takes the slave view.
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic              flush;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_inst;
    logic              fetch_err;
    logic              busy;
    logic [ADDR_W-1:0] W_ADDR;
    logic              W_STB;
    logic [DATA_W-1:0] W_DAT_I;
    logic              W_ACK;

    modport master (
        input  fetch_req, fetch_addr, fetch_ack, flush, W_DAT_I, W_ACK,
        output fetch_valid, fetch_inst, fetch_err, busy, W_ADDR, W_STB
    );

    modport slave (
        output fetch_req, fetch_addr, fetch_ack, flush, W_DAT_I, W_ACK,
        input  fetch_valid, fetch_inst, fetch_err, busy, W_ADDR, W_STB
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit with a one-entry sequential prefetch buffer.
// Define FETCH_TIMEOUT_EN to add a bus-cycle watchdog of TIMEOUT clk cycles.
module inst_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          W_RST,
    inst_fetch_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_PREF = 2'd3;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("inst_fetch: TIMEOUT must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic              w_stb_q, w_stb_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_inst_q, fetch_inst_d;
    logic              fetch_err_q, fetch_err_d;
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [DATA_W-1:0] pf_data_q, pf_data_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              discard_q, discard_d;
    logic              eval_req;
    logic              tmo_hit;

`ifdef FETCH_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = w_stb_q && !bus.W_ACK && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    // Any state change or strobe gap starts a fresh bus cycle, so the count restarts.
    always_comb begin
        tmo_cnt_d = (w_stb_q && w_stb_d && (state_d == state_q)) ? tmo_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (W_RST) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        w_stb_d       = w_stb_q;
        w_addr_d      = w_addr_q;
        fetch_valid_d = fetch_valid_q;
        fetch_inst_d  = fetch_inst_q;
        fetch_err_d   = fetch_err_q;
        pf_valid_d    = pf_valid_q;
        pf_addr_d     = pf_addr_q;
        pf_data_d     = pf_data_q;
        last_addr_d   = last_addr_q;
        discard_d     = discard_q;
        eval_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                eval_req = bus.fetch_req && !bus.flush;
            end

            ST_REQ: begin
                if (bus.flush) discard_d = 1'b1;
                if (bus.W_ACK || tmo_hit) begin
                    w_stb_d   = 1'b0;
                    discard_d = 1'b0;
                    if (discard_q || bus.flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        fetch_valid_d = 1'b1;
                        fetch_err_d   = !bus.W_ACK;
                        fetch_inst_d  = bus.W_ACK ? bus.W_DAT_I : '0;
                        state_d       = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (bus.flush) begin
                    fetch_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else if (bus.fetch_ack) begin
                    fetch_valid_d = 1'b0;
                    w_addr_d      = {last_addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                    w_stb_d       = 1'b1;
                    state_d       = ST_PREF;
                end
            end

            default: begin // ST_PREF
                if (bus.flush) discard_d = 1'b1;
                if (bus.W_ACK || tmo_hit) begin
                    w_stb_d   = 1'b0;
                    discard_d = 1'b0;
                    if (bus.W_ACK && !discard_q && !bus.flush) begin
                        pf_valid_d = 1'b1;
                        pf_addr_d  = w_addr_q;
                        pf_data_d  = bus.W_DAT_I;
                    end else begin
                        pf_valid_d = 1'b0;
                    end
                    if (bus.fetch_req && !bus.flush) eval_req = 1'b1;
                    else                             state_d  = ST_IDLE;
                end
            end
        endcase

        // Request evaluation sees the buffer as just updated above, so a PREF fill can hit at once.
        if (eval_req) begin
            last_addr_d = bus.fetch_addr;
            if (bus.fetch_addr[1:0] != 2'b00) begin
                fetch_valid_d = 1'b1;
                fetch_err_d   = 1'b1;
                fetch_inst_d  = '0;
                state_d       = ST_HOLD;
            end else if (pf_valid_d && (bus.fetch_addr == pf_addr_d)) begin
                fetch_valid_d = 1'b1;
                fetch_err_d   = 1'b0;
                fetch_inst_d  = pf_data_d;
                pf_valid_d    = 1'b0;
                state_d       = ST_HOLD;
            end else begin
                pf_valid_d = 1'b0;
                w_addr_d   = bus.fetch_addr;
                w_stb_d    = 1'b1;
                state_d    = ST_REQ;
            end
        end

        if (bus.flush) pf_valid_d = 1'b0;
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (W_RST) begin
            state_q       <= ST_IDLE;
            w_stb_q       <= 1'b0;
            w_addr_q      <= '0;
            fetch_valid_q <= 1'b0;
            fetch_inst_q  <= '0;
            fetch_err_q   <= 1'b0;
            pf_valid_q    <= 1'b0;
            pf_addr_q     <= '0;
            pf_data_q     <= '0;
            last_addr_q   <= '0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_stb_q       <= w_stb_d;
            w_addr_q      <= w_addr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_inst_q  <= fetch_inst_d;
            fetch_err_q   <= fetch_err_d;
            pf_valid_q    <= pf_valid_d;
            pf_addr_q     <= pf_addr_d;
            pf_data_q     <= pf_data_d;
            last_addr_q   <= last_addr_d;
            discard_q     <= discard_d;
        end
    end

    assign bus.W_STB       = w_stb_q;
    assign bus.W_ADDR      = w_addr_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_inst  = fetch_inst_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed scoreboard bench for inst_fetch; honours FETCH_TIMEOUT_EN for the watchdog case.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_inst_fetch;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    typedef struct packed {
        logic [DW-1:0] inst;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic W_RST;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .W_RST (W_RST),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [DW-1:0] inst, input logic err);
        exp_t e;
        e.inst = inst;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Pops the oldest expected delivery and compares it with what the DUT presents now.
    task automatic expect_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s.sb: observed delivery expected none queued", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".valid"}, 64'(bus.fetch_valid), 64'(1'b1));
        check({tag, ".inst"},  64'(bus.fetch_inst),  64'(e.inst));
        check({tag, ".err"},   64'(bus.fetch_err),   64'(e.err));
    endtask

    task automatic bus_ack(input logic [DW-1:0] data);
        bus.W_DAT_I = data;
        bus.W_ACK   = 1'b1;
        tick();
        bus.W_ACK   = 1'b0;
        bus.W_DAT_I = '0;
    endtask

    task automatic request(input logic [AW-1:0] addr);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        tick();
    endtask

    task automatic cpu_ack();
        bus.fetch_req = 1'b0;
        bus.fetch_ack = 1'b1;
        tick();
        bus.fetch_ack = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b1;
        tick();
        bus.flush     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.fetch_ack  = 1'b0;
        bus.flush      = 1'b0;
        bus.W_DAT_I    = '0;
        bus.W_ACK      = 1'b0;
        W_RST          = 1'b1;
        tick();
        tick();
        check("rst.stb",   64'(bus.W_STB),       64'(0));
        check("rst.addr",  64'(bus.W_ADDR),      64'(0));
        check("rst.valid", 64'(bus.fetch_valid), 64'(0));
        check("rst.inst",  64'(bus.fetch_inst),  64'(0));
        check("rst.err",   64'(bus.fetch_err),   64'(0));
        check("rst.busy",  64'(bus.busy),        64'(0));
        W_RST = 1'b0;
        tick();

        // Cold fetch: bus acks on the third cycle of the strobe.
        push_exp(32'hDEADBEEF, 1'b0);
        request(32'h100);
        check("cold.stb",  64'(bus.W_STB),  64'(1));
        check("cold.addr", 64'(bus.W_ADDR), 64'(32'h100));
        check("cold.busy", 64'(bus.busy),   64'(1));
        tick();
        tick();
        check("cold.early_valid", 64'(bus.fetch_valid), 64'(0));
        bus_ack(32'hDEADBEEF);
        expect_out("cold");
        check("cold.stb_drop", 64'(bus.W_STB), 64'(0));

        cpu_ack();
        check("pref.valid_drop", 64'(bus.fetch_valid), 64'(0));
        check("pref.stb",        64'(bus.W_STB),       64'(1));
        check("pref.addr",       64'(bus.W_ADDR),      64'(32'h104));
        bus_ack(32'h12345678);
        check("pref.idle", 64'(bus.busy),  64'(0));
        check("pref.done", 64'(bus.W_STB), 64'(0));

        // Sequential request hits the buffer: one cycle, no bus activity.
        push_exp(32'h12345678, 1'b0);
        request(32'h104);
        expect_out("hit");
        check("hit.no_stb", 64'(bus.W_STB), 64'(0));
        cpu_ack();
        check("pref2.stb",  64'(bus.W_STB),  64'(1));
        check("pref2.addr", 64'(bus.W_ADDR), 64'(32'h108));

        // Non-sequential request while the prefetch is still on the bus.
        push_exp(32'hCAFEF00D, 1'b0);
        request(32'h200);
        check("miss.addr_stable", 64'(bus.W_ADDR),      64'(32'h108));
        check("miss.wait_valid",  64'(bus.fetch_valid), 64'(0));
        bus_ack(32'h11111111);
        check("miss.addr",     64'(bus.W_ADDR),      64'(32'h200));
        check("miss.stb",      64'(bus.W_STB),       64'(1));
        check("miss.no_valid", 64'(bus.fetch_valid), 64'(0));
        tick();
        bus_ack(32'hCAFEF00D);
        expect_out("miss");

        // Flush together with fetch_ack in HOLD: no prefetch.
        bus.fetch_req = 1'b0;
        bus.flush     = 1'b1;
        bus.fetch_ack = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.fetch_ack = 1'b0;
        check("fa.valid", 64'(bus.fetch_valid), 64'(0));
        check("fa.stb",   64'(bus.W_STB),       64'(0));
        check("fa.busy",  64'(bus.busy),        64'(0));
        tick();
        check("fa.no_pref", 64'(bus.W_STB), 64'(0));

        // Flush during REQ; the ack lands two cycles later and is dropped.
        request(32'h204);
        check("fr.stb", 64'(bus.W_STB), 64'(1));
        pulse_flush();
        check("fr.stb_held", 64'(bus.W_STB), 64'(1));
        tick();
        bus_ack(32'hBAD0BAD0);
        check("fr.valid", 64'(bus.fetch_valid), 64'(0));
        check("fr.busy",  64'(bus.busy),        64'(0));
        check("fr.stb",   64'(bus.W_STB),       64'(0));
        tick();
        check("fr.valid_later", 64'(bus.fetch_valid), 64'(0));

        // A filled buffer is cleared by a flush in IDLE, so the next request misses.
        push_exp(32'hA5A5A5A5, 1'b0);
        request(32'h208);
        bus_ack(32'hA5A5A5A5);
        expect_out("pfc.first");
        cpu_ack();
        check("pfc.pref_addr", 64'(bus.W_ADDR), 64'(32'h20C));
        bus_ack(32'h5A5A5A5A);
        pulse_flush();
        push_exp(32'h77777777, 1'b0);
        request(32'h20C);
        check("pfc.miss_stb",   64'(bus.W_STB),       64'(1));
        check("pfc.miss_valid", 64'(bus.fetch_valid), 64'(0));
        bus_ack(32'h77777777);
        expect_out("pfc.second");
        pulse_flush();

        // Address wrap on the prefetch, then a hit at address 0.
        push_exp(32'h0BADF00D, 1'b0);
        request(32'hFFFF_FFFC);
        bus_ack(32'h0BADF00D);
        expect_out("wrap.fetch");
        cpu_ack();
        check("wrap.stb",  64'(bus.W_STB),  64'(1));
        check("wrap.addr", 64'(bus.W_ADDR), 64'(0));
        bus_ack(32'h13579BDF);
        push_exp(32'h13579BDF, 1'b0);
        request(32'h0);
        expect_out("wrap.hit");
        check("wrap.hit_no_stb", 64'(bus.W_STB), 64'(0));
        pulse_flush();

        // Misaligned request: error without a bus cycle.
        push_exp(32'h0, 1'b1);
        request(32'h102);
        expect_out("mis");
        check("mis.no_stb", 64'(bus.W_STB), 64'(0));
        pulse_flush();
        check("mis.flushed", 64'(bus.fetch_valid), 64'(0));

        // Stray ack in IDLE is ignored.
        bus_ack(32'hFFFF0000);
        check("late.busy",  64'(bus.busy),        64'(0));
        check("late.valid", 64'(bus.fetch_valid), 64'(0));

        // Reset in the middle of a bus cycle, followed by the late ack.
        request(32'h400);
        check("mrst.stb_on", 64'(bus.W_STB), 64'(1));
        bus.fetch_req = 1'b0;
        W_RST         = 1'b1;
        tick();
        W_RST         = 1'b0;
        check("mrst.stb",  64'(bus.W_STB), 64'(0));
        check("mrst.busy", 64'(bus.busy),  64'(0));
        bus_ack(32'h44444444);
        check("mrst.late_valid", 64'(bus.fetch_valid), 64'(0));
        check("mrst.late_busy",  64'(bus.busy),        64'(0));

`ifdef FETCH_TIMEOUT_EN
        // Bus never acks: strobe lasts TIMEOUT cycles, then an error is delivered.
        push_exp(32'h0, 1'b1);
        request(32'h500);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.W_STB) break;
            cnt++;
            tick();
        end
        check("tmo.stb_cycles", 64'(cnt), 64'(TMO));
        expect_out("tmo");
        pulse_flush();
`else
        // Without the watchdog the strobe waits indefinitely.
        push_exp(32'h600DD00D, 1'b0);
        request(32'h500);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.W_STB) cnt++;
            tick();
        end
        check("notmo.stb_cycles", 64'(cnt), 64'(100));
        check("notmo.stb",        64'(bus.W_STB), 64'(1));
        bus_ack(32'h600DD00D);
        expect_out("notmo");
        pulse_flush();
`endif

        check("end.sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
